// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: MIPS decode-and-issue stage producing the ALU interface
// (val1 / val2 / EXE_CMD). Reads the register file, builds immediates, keeps a
// 32-entry scoreboard of in-flight writes, stalls on RAW/WAW hazards, and
// presents each decoded command in a registered valid/ready output slot.
// Build option: define ALU_ISSUE_FWD_EN to bypass wb_data into a source operand
// when the only hazard on that source is a pending write completing this cycle.
module alu_cmd_issue #(
  parameter int WORD_LEN    = 32,
  parameter int EXE_CMD_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_LEN-1:0]    in_instr,
  output logic                   in_ready,
  output logic [4:0]             rs_addr,
  output logic [4:0]             rt_addr,
  input  logic [WORD_LEN-1:0]    rs_data,
  input  logic [WORD_LEN-1:0]    rt_data,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_dest,
  input  logic [WORD_LEN-1:0]    wb_data,
  input  logic                   flush,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [WORD_LEN-1:0]    val1,
  output logic [WORD_LEN-1:0]    val2,
  output logic [EXE_CMD_LEN-1:0] EXE_CMD,
  output logic [4:0]             ex_dest,
  output logic                   ex_wb_en,
  output logic                   illegal
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign opcode  = in_instr[31:26];
  assign rs      = in_instr[25:21];
  assign rt      = in_instr[20:16];
  assign rd      = in_instr[15:11];
  assign imm16   = in_instr[15:0];
  assign funct   = in_instr[5:0];
  assign rs_addr = rs;
  assign rt_addr = rt;

  // Output slot and scoreboard state
  logic                   ex_valid_reg;
  logic [WORD_LEN-1:0]    val1_reg;
  logic [WORD_LEN-1:0]    val2_reg;
  logic [EXE_CMD_LEN-1:0] exe_cmd_reg;
  logic [4:0]             ex_dest_reg;
  logic                   ex_wb_en_reg;
  logic                   illegal_reg;
  logic [31:0]            pending_reg;
  logic [31:0]            pending_next;

  // Decode results
  logic                   dec_legal;
  logic [EXE_CMD_LEN-1:0] dec_cmd;
  logic [4:0]             dec_dest;
  logic                   dec_use_rt;
  logic                   dec_is_imm;
  logic [WORD_LEN-1:0]    dec_imm_val;

  // Decode: classify the instruction, pick command, destination and immediate
  always_comb begin
    dec_legal   = 1'b0;
    dec_cmd     = '0;
    dec_dest    = '0;
    dec_use_rt  = 1'b0;
    dec_is_imm  = 1'b0;
    dec_imm_val = '0;
    if (opcode == 6'h00) begin
      // ALU funct codes 0x20-0x27 plus SLT/SLTU; command is the low funct nibble
      if (((funct >= 6'h20) && (funct <= 6'h27)) || (funct == 6'h2A) || (funct == 6'h2B)) begin
        dec_legal  = 1'b1;
        dec_cmd    = EXE_CMD_LEN'(funct[3:0]);
        dec_dest   = rd;
        dec_use_rt = 1'b1;
      end
    end else if ((opcode >= 6'h08) && (opcode <= 6'h0E)) begin
      dec_legal  = 1'b1;
      dec_cmd    = EXE_CMD_LEN'(opcode[3:0]);
      dec_dest   = rt;
      dec_is_imm = 1'b1;
      // Arithmetic/compare immediates sign-extend (SLTIU too); logical ones zero-extend
      if (opcode <= 6'h0B) begin
        dec_imm_val = {{(WORD_LEN-16){imm16[15]}}, imm16};
      end else begin
        dec_imm_val = {{(WORD_LEN-16){1'b0}}, imm16};
      end
    end
  end

  // Hazard detection against the scoreboard and the not-yet-transferred slot
  logic rs_slot_hit;
  logic rt_slot_hit;
  logic dst_slot_hit;
  logic rs_fwd;
  logic rt_fwd;
  logic rs_haz;
  logic rt_haz;
  logic dst_haz;
  logic hazard;
  logic slot_free;
  logic do_issue;
  logic transfer;
  logic [WORD_LEN-1:0] op1;
  logic [WORD_LEN-1:0] op2;

  assign rs_slot_hit  = ex_valid_reg && ex_wb_en_reg && (ex_dest_reg == rs);
  assign rt_slot_hit  = ex_valid_reg && ex_wb_en_reg && (ex_dest_reg == rt);
  assign dst_slot_hit = ex_valid_reg && ex_wb_en_reg && (ex_dest_reg == dec_dest);

`ifdef ALU_ISSUE_FWD_EN
  // A source waiting only on a pending write that lands this cycle takes wb_data
  assign rs_fwd = pending_reg[rs] && !rs_slot_hit && wb_valid && (wb_dest == rs);
  assign rt_fwd = pending_reg[rt] && !rt_slot_hit && wb_valid && (wb_dest == rt);
`else
  assign rs_fwd = 1'b0;
  assign rt_fwd = 1'b0;
  logic wb_data_unused;
  assign wb_data_unused = ^wb_data;
`endif

  // Register 0 never carries a hazard; destination checked too so WAW stalls
  assign rs_haz  = (rs != 5'd0) && (pending_reg[rs] || rs_slot_hit) && !rs_fwd;
  assign rt_haz  = (rt != 5'd0) && (pending_reg[rt] || rt_slot_hit) && !rt_fwd;
  assign dst_haz = (dec_dest != 5'd0) && (pending_reg[dec_dest] || dst_slot_hit);
  assign hazard  = dec_legal && (rs_haz || (dec_use_rt && rt_haz) || dst_haz);

  assign slot_free = !ex_valid_reg || ex_ready;
  assign in_ready  = in_valid && !hazard && slot_free && !flush;
  assign do_issue  = in_ready && dec_legal;
  // flush beats ex_ready: a flushed entry is never considered transferred
  assign transfer  = ex_valid_reg && ex_ready && !flush;

  assign op1 = rs_fwd ? wb_data : rs_data;
  assign op2 = dec_is_imm ? dec_imm_val : (rt_fwd ? wb_data : rt_data);

  // Output slot: load on issue, drain on transfer, discard on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_reg <= 1'b0;
      val1_reg     <= '0;
      val2_reg     <= '0;
      exe_cmd_reg  <= '0;
      ex_dest_reg  <= '0;
      ex_wb_en_reg <= 1'b0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (do_issue) begin
      ex_valid_reg <= 1'b1;
      val1_reg     <= op1;
      val2_reg     <= op2;
      exe_cmd_reg  <= dec_cmd;
      ex_dest_reg  <= dec_dest;
      ex_wb_en_reg <= (dec_dest != 5'd0);
    end else if (ex_ready) begin
      ex_valid_reg <= 1'b0;
    end
  end

  // Illegal pulse: one cycle after an unsupported instruction is consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_reg <= 1'b0;
    end else begin
      illegal_reg <= in_ready && !dec_legal;
    end
  end

  // Scoreboard next state per register: a set from a transfer overrides a clear
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pending
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        assign pending_next[gi] =
          (transfer && ex_wb_en_reg && (ex_dest_reg == 5'(gi))) ||
          (pending_reg[gi] && !(wb_valid && (wb_dest == 5'(gi))));
      end
    end
  endgenerate

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign ex_valid = ex_valid_reg;
  assign val1     = val1_reg;
  assign val2     = val2_reg;
  assign EXE_CMD  = exe_cmd_reg;
  assign ex_dest  = ex_dest_reg;
  assign ex_wb_en = ex_wb_en_reg;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Testbench for alu_cmd_issue: directed scenarios plus randomized instruction
// stream. Expected commands come from an architectural model (register values
// as of program order, decode rules as plain arithmetic) pushed to a queue at
// acceptance; a separate monitor pops and compares whatever the DUT presents.
module tb_alu_cmd_issue;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] val1, val2;
  logic [3:0]  EXE_CMD;
  logic [4:0]  ex_dest;
  logic        ex_wb_en;
  logic        illegal;

  alu_cmd_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .val1(val1), .val2(val2), .EXE_CMD(EXE_CMD),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Register file model: reads see only writes completed in earlier cycles
  logic [31:0] rf [32];
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  typedef struct { logic [31:0] v1; logic [31:0] v2; logic [3:0] cmd; logic [4:0] dest; logic wb; int acc; } exp_t;
  typedef struct { int due; logic [4:0] dest; logic [31:0] data; } wb_t;

  exp_t exp_q[$];
  int   ill_q[$];
  wb_t  pipe_q[$];
  int   inflight [32];
  int   last_wb_cyc [32];
  bit   front_seen;
  int   cyc, acc_cyc, last_due;
  int   rdy_mode;      // 0 random, 1 always ready, 2 never ready
  bit   flush_req, rand_flush_en, fixed_delay;
  int   n_checks, n_pass;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference decode from the instruction-set rules
  function automatic void model(input logic [31:0] ins, output bit legal, output logic [3:0] cmd,
                                output bit use_rt, output logic [4:0] dest, output bit is_imm,
                                output logic [31:0] imm_val);
    int op, fn, s;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    legal = 0; cmd = 0; use_rt = 0; dest = 0; is_imm = 0; imm_val = 0;
    if (op == 0 && ((fn >= 32 && fn <= 39) || fn == 42 || fn == 43)) begin
      legal = 1; cmd = 4'(fn % 16); use_rt = 1; dest = ins[15:11];
    end else if (op >= 8 && op <= 14) begin
      legal = 1; cmd = 4'(op); dest = ins[20:16]; is_imm = 1;
      s = int'(ins[15:0]);
      if (op <= 11 && s >= 32768) s = s - 65536;
      imm_val = 32'(s);
    end
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    int k, j;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    k = $urandom_range(0, 99);
    if (k < 45) begin
      j = $urandom_range(0, 9);
      return {6'd0, a, b, c, 5'd0, (j < 8) ? 6'(32 + j) : 6'(42 + j - 8)};
    end else if (k < 85) begin
      return {6'($urandom_range(8, 14)), a, b, 16'($urandom)};
    end else if (k < 92) begin
      return {6'd0, a, b, c, 5'd0, 6'($urandom_range(0, 31))};
    end
    return {6'($urandom_range(15, 63)), 26'($urandom)};
  endfunction

  // One clock cycle, entered and left at the falling edge
  task automatic tick(output bit acc);
    bit legal, use_rt, is_imm, ok;
    logic [3:0]  cmd;
    logic [4:0]  dest, rs, rt;
    logic [31:0] immv;
    exp_t e;
    wb_t  w;
    cyc++;
    wb_valid = 0; wb_dest = 0; wb_data = 0;
    if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
      w = pipe_q.pop_front();
      wb_valid = 1; wb_dest = w.dest; wb_data = w.data;
    end
    case (rdy_mode)
      0: ex_ready = ($urandom_range(0, 9) < 8);
      1: ex_ready = 1;
      default: ex_ready = 0;
    endcase
    flush = flush_req || (rand_flush_en && $urandom_range(0, 49) == 0);
    flush_req = 0;
    #2;
    acc = in_valid && in_ready;
    legal = 0; dest = 0;
    if (flush && in_valid) chk("in_ready_under_flush", in_ready, 0);
    if (acc) begin
      model(in_instr, legal, cmd, use_rt, dest, is_imm, immv);
      rs = in_instr[25:21];
      rt = in_instr[20:16];
      if (!legal) begin
        ill_q.push_back(cyc);
      end else begin
        ok = 1;
        if (rs != 0 && !(inflight[rs] == 0 || (FWD && inflight[rs] == 1 && wb_valid && wb_dest == rs))) ok = 0;
        if (use_rt && rt != 0 && !(inflight[rt] == 0 || (FWD && inflight[rt] == 1 && wb_valid && wb_dest == rt))) ok = 0;
        if (dest != 0 && inflight[dest] != 0) ok = 0;
        chk("hazard_respected", 32'(ok), 1);
        e.v1  = (rs == 0) ? 32'd0 : ((wb_valid && wb_dest == rs) ? wb_data : rf[rs]);
        e.v2  = is_imm ? immv : ((rt == 0) ? 32'd0 : ((wb_valid && wb_dest == rt) ? wb_data : rf[rt]));
        e.cmd = cmd; e.dest = dest; e.wb = (dest != 0); e.acc = cyc;
        exp_q.push_back(e);
      end
      acc_cyc = cyc;
    end
    if (wb_valid) begin
      inflight[wb_dest]--;
      last_wb_cyc[wb_dest] = cyc;
    end
    if (acc && legal && dest != 0) inflight[dest]++;
    @(posedge clk);
    #1;
    if (wb_valid) rf[wb_dest] = wb_data;
    @(negedge clk);
  endtask

  // Present an instruction until accepted (bounded)
  task automatic issue(input logic [31:0] ins, output int acc_at);
    bit got;
    got = 0;
    in_valid = 1; in_instr = ins;
    for (int w = 0; w < 60 && !got; w++) tick(got);
    chk("accepted_in_budget", 32'(got), 1);
    in_valid = 0;
    acc_at = acc_cyc;
  endtask

  task automatic idle(input int n);
    bit got;
    in_valid = 0;
    for (int i = 0; i < n; i++) tick(got);
  endtask

  // Monitor: compare every presented slot against the scoreboard queue
  initial begin
    exp_t e;
    wb_t  w;
    int   a;
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        if (illegal) begin
          chk("illegal_expected", 32'(ill_q.size() > 0), 1);
          if (ill_q.size() > 0) begin
            a = ill_q.pop_front();
            chk("illegal_latency", cyc, a + 1);
            $display("txn illegal consumed at cycle %0d", a);
          end
        end
        if (ex_valid) begin
          chk("issue_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("val1", val1, e.v1);
            chk("val2", val2, e.v2);
            chk("exe_cmd", 32'(EXE_CMD), 32'(e.cmd));
            chk("ex_dest", 32'(ex_dest), 32'(e.dest));
            chk("ex_wb_en", 32'(ex_wb_en), 32'(e.wb));
            if (!front_seen) begin
              chk("issue_latency", cyc, e.acc + 1);
              front_seen = 1;
            end
            if (flush) begin
              void'(exp_q.pop_front());
              front_seen = 0;
              if (e.wb) inflight[e.dest]--;
              $display("txn flushed cmd=%h dest=%0d", e.cmd, e.dest);
            end else if (ex_ready) begin
              void'(exp_q.pop_front());
              front_seen = 0;
              if (e.wb) begin
                w.due = fixed_delay ? cyc + 3 : cyc + $urandom_range(1, 4);
                if (w.due <= last_due) w.due = last_due + 1;
                last_due = w.due;
                w.dest = e.dest;
                w.data = $urandom;
                pipe_q.push_back(w);
              end
              $display("txn issued cmd=%h val1=%h val2=%h dest=%0d wb_en=%0d", e.cmd, e.v1, e.v2, e.dest, e.wb);
            end
          end
        end
      end
    end
  end

  initial begin
    int a1, a2, fc;
    bit got;
    n_checks = 0; n_pass = 0; cyc = 0; acc_cyc = 0; last_due = 0;
    rdy_mode = 1; flush_req = 0; rand_flush_en = 0; fixed_delay = 1; front_seen = 0;
    rst = 0; in_valid = 0; in_instr = 0; wb_valid = 0; wb_dest = 0; wb_data = 0;
    flush = 0; ex_ready = 0;
    rf[0] = 0;
    for (int r = 1; r < 32; r++) rf[r] = $urandom;
    for (int r = 0; r < 32; r++) begin inflight[r] = 0; last_wb_cyc[r] = -100; end
    repeat (2) @(negedge clk);
    rst = 1;

    // Asynchronous reset while the slot holds an entry
    rdy_mode = 2;
    issue({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, a1);
    chk("pre_reset_valid", 32'(ex_valid), 1);
    #1 rst = 0;
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_val1", val1, 0);
    chk("rst_val2", val2, 0);
    chk("rst_exe_cmd", 32'(EXE_CMD), 0);
    chk("rst_ex_dest", 32'(ex_dest), 0);
    chk("rst_ex_wb_en", 32'(ex_wb_en), 0);
    chk("rst_illegal", 32'(illegal), 0);
    exp_q.delete(); ill_q.delete(); pipe_q.delete(); front_seen = 0; wb_valid = 0;
    for (int r = 0; r < 32; r++) inflight[r] = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;

    // ADDU after reset
    rdy_mode = 1;
    issue({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, a1);
    chk("addu_valid", 32'(ex_valid), 1);
    chk("addu_cmd", 32'(EXE_CMD), 32'h1);

    // ADDI sign extension, ORI zero extension, back-to-back
    issue({6'h08, 5'd0, 5'd4, 16'hFFFF}, a1);
    chk("addi_val2", val2, 32'hFFFF_FFFF);
    chk("addi_cmd", 32'(EXE_CMD), 32'h8);
    issue({6'h0D, 5'd0, 5'd5, 16'hFFFF}, a2);
    chk("ori_val2", val2, 32'h0000_FFFF);
    chk("ori_cmd", 32'(EXE_CMD), 32'hD);
    chk("throughput_one_per_cycle", a2 - a1, 1);
    idle(8);

    // RAW: SUB depends on ADD writeback 3 cycles after transfer
    issue({6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'h20}, a1);
    issue({6'd0, 5'd6, 5'd1, 5'd7, 5'd0, 6'h22}, a2);
    chk("sub_accept_vs_wb", a2 - last_wb_cyc[6], FWD ? 0 : 1);
    idle(8);

    // Held slot, then flush; follow-up reader must not stall
    rdy_mode = 2;
    issue({6'h08, 5'd0, 5'd9, 16'd5}, a1);
    in_valid = 1; in_instr = {6'h0D, 5'd0, 5'd10, 16'd1};
    for (int i = 0; i < 4; i++) begin
      tick(got);
      chk("in_ready_while_held", 32'(got), 0);
    end
    in_valid = 0;
    flush_req = 1;
    tick(got);
    fc = cyc;
    chk("ex_valid_after_flush", 32'(ex_valid), 0);
    rdy_mode = 1;
    issue({6'd0, 5'd9, 5'd0, 5'd11, 5'd0, 6'h20}, a1);
    chk("reader_after_flush_no_stall", a1 - fc, 1);
    idle(6);

    // LW is unsupported
    issue({6'h23, 5'd1, 5'd2, 16'h0004}, a1);
    chk("lw_illegal_pulse", 32'(illegal), 1);
    chk("lw_no_issue", 32'(ex_valid), 0);
    idle(1);
    chk("lw_pulse_one_cycle", 32'(illegal), 0);

    // Write to $0 then read $0
    issue({6'h08, 5'd1, 5'd0, 16'd7}, a1);
    chk("dest0_wb_en", 32'(ex_wb_en), 0);
    issue({6'd0, 5'd0, 5'd0, 5'd8, 5'd0, 6'h20}, a2);
    chk("reg0_no_stall", a2 - a1, 1);
    idle(6);

    // Randomized stream with backpressure and occasional flush
    rdy_mode = 0; rand_flush_en = 1; fixed_delay = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) idle(1);
      issue(rand_instr(), a1);
    end
    rdy_mode = 1; rand_flush_en = 0;
    idle(20);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("illegal_queue_drained", ill_q.size(), 0);
    chk("writeback_drained", pipe_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issue.md
# alu_cmd_issue

Decode-and-issue stage that produces the ALU's operand and command interface (`val1`, `val2`, `EXE_CMD`) from 32-bit MIPS instructions. It sits between the IF/ID register and the EX stage. It reads the register file, builds immediates, and tracks in-flight writes with a 32-entry scoreboard to stall on hazards. It holds results in a registered valid/ready output slot.

## Interface
Parameters (from `defines.v`):
- `WORD_LEN`, 32, operand/instruction width
- `EXE_CMD_LEN`, 4, ALU command width

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `in_valid` in 1: instruction available
- `in_instr` in 32: instruction word
- `in_ready` out 1: instruction consumed this cycle
- `rs_addr`, `rt_addr` out 5: register file read addresses, combinational from `in_instr[25:21]` / `[20:16]`
- `rs_data`, `rt_data` in 32: register file read data (reflects writes completed in earlier cycles only)
- `wb_valid` in 1, `wb_dest` in 5, `wb_data` in 32: EX result written back this cycle
- `flush` in 1: discard output slot contents
- `ex_valid` out 1, `ex_ready` in 1: output handshake
- `val1`, `val2` out 32, `EXE_CMD` out 4: ALU operands/command
- `ex_dest` out 5, `ex_wb_en` out 1: destination register, write enable
- `illegal` out 1: one-cycle pulse on unsupported instruction

## Operation
- R-type (opcode 0): funct 0x20–0x27 → `EXE_CMD`=funct[3:0]; 0x2A→1010; 0x2B→1011. `val1`=rs, `val2`=rt, dest=rd.
- I-type opcode 0x08–0x0E → `EXE_CMD`=opcode[3:0]. `val1`=rs, dest=rt.
  - `val2`=sign-extended imm16 for 0x08–0x0B (SLTIU included).
  - `val2`=zero-extended imm16 for 0x0C–0x0E.
- Any other encoding is illegal: it is consumed (`in_ready`=1), nothing is issued, and `illegal`=1 for one cycle.
- Dest 0 forces `ex_wb_en`=0. Source register 0 never causes a hazard.
- Scoreboard `pending[31:0]`:
  - Bit set when an entry with `ex_wb_en` transfers (`ex_valid`&&`ex_ready`).
  - Bit cleared on `wb_valid` for `wb_dest`.
  - Same-register set and clear in one cycle: set wins.
- Hazard for a source or destination register r (r≠0): `pending[r]`, or the output slot is valid with `ex_wb_en` and `ex_dest`=r. Destination is checked too, so WAW also stalls. Only the fields the instruction actually uses are checked.
- `in_ready` = `in_valid` && !hazard && (!`ex_valid` || `ex_ready`) && !`flush`.
- `flush` clears `ex_valid` next edge. The flushed entry never sets `pending`. Bits of already-transferred entries remain until writeback.

## Timing
- Latency: instruction accepted at edge N → `ex_valid`=1 after edge N. Throughput is 1 per cycle with no hazard.
- Output slot holds stable while `ex_valid`&&!`ex_ready`.
- Without forwarding, a stalled consumer is accepted in the cycle after the `wb_valid` that clears its hazard.
- Reset (asynchronous, any time):
  - `ex_valid`=0; `val1`/`val2`/`EXE_CMD`/`ex_dest`/`ex_wb_en`=0; `illegal`=0; `pending`=0.
  - In-flight state is lost. `in_ready` follows its equation.
- `flush` and `in_valid` in the same cycle: `in_ready`=0. `flush` has priority over `ex_ready`.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: when a source hazard is caused only by `pending[r]`, and `wb_valid`&&`wb_dest`=r in the same cycle, the hazard is cancelled for that source. `wb_data` is latched into the corresponding operand, saving one cycle per RAW stall. WAW and output-slot hazards still stall.
- Not defined: no bypass. Operands come only from `rs_data`/`rt_data`.

## Test plan
- Reset low mid-stream with `ex_valid`=1 → all outputs 0 immediately. After release, ADDU $3,$1,$2 issues with `EXE_CMD`=0001 one cycle after acceptance.
- ADDI $4,$0,-1 then ORI $5,$0,0xFFFF → `val2`=0xFFFFFFFF with `EXE_CMD`=1000, then `val2`=0x0000FFFF with `EXE_CMD`=1101.
- ADD $6,… then SUB $7,$6,$1 with writeback 3 cycles after transfer:
  - Without the macro, SUB is accepted the cycle after `wb_valid`.
  - With the macro, it is accepted in the `wb_valid` cycle and `val1`=`wb_data`.
- `ex_ready`=0 for 4 cycles → outputs held, `in_ready`=0. Then `flush` → `ex_valid`=0 next cycle and no `pending` bit set (a follow-up reader of that dest issues without stall).
- Opcode 0x23 (LW) → `illegal` pulses once, `in_ready`=1, `ex_valid` stays 0.
- Write to $0 followed by a reader of $0 → `ex_wb_en`=0, no stall.
